asl_result_sequencer: RTL and testbench
=======================================

# asl_result_sequencer

Sequences the 29-class argmax pipeline at the classifier output. It collects one frame of 8-bit class scores from the final fully-connected layer as a serial stream and launches the assembled vector into the 3-cycle argmax tree. It then applies a confidence threshold and an N-frame stability filter to the winning index, and hands each stable letter to the display/UART consumer over a valid/ready handshake.

## Interface
- NUM_CLASS, 29, scores per frame; argmax vector width
- ARGMAX_LAT, 3, fixed argmax pipeline latency in cycles; informational, not used for capture
- TIMEOUT, 15, maximum WAIT cycles before a missing argmax result is an error
- CONF_MIN, 8'd64, minimum winning score for a frame to count toward stability
- STABLE_N, 3, consecutive qualifying frames with the same index required to emit
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- score_i  in  8  class score beat
- score_valid_i  in  1  beat valid
- score_last_i  in  1  marks the final beat of a frame
- score_ready_o  out  1  beat accepted when valid&ready
- am_data_o  out  8 x NUM_CLASS  unpacked score vector to argmax, slot k = k-th beat
- am_valid_o  out  1  one-cycle launch strobe to argmax
- am_data_i  in  8  winning score from argmax
- am_idx_i  in  5  winning index from argmax
- am_valid_i  in  1  argmax result strobe
- res_idx_o  out  5  reported class index
- res_conf_o  out  8  reported winning score
- res_valid_o  out  1  result valid; held until res_ready_i
- res_ready_i  in  1  consumer ready
- frame_err_o  out  1  one-cycle error pulse
- busy_o  out  1  high in every state except COLLECT with beat count 0

## Operation
- States: COLLECT, DRAIN, LAUNCH, WAIT, FILTER, OUTPUT.
- COLLECT: score_ready_o=1. Each accepted beat writes slot cnt and increments cnt.
  - last with cnt==NUM_CLASS-1 goes to LAUNCH and resets cnt to 0.
  - last with cnt<NUM_CLASS-1 (short frame) pulses frame_err_o, resets cnt to 0, and stays in COLLECT.
  - Beat at cnt==NUM_CLASS-1 without last (long frame) pulses frame_err_o and goes to DRAIN.
- DRAIN: score_ready_o=1. Beats are discarded until a last beat is accepted, then the block returns to COLLECT with cnt=0.
- LAUNCH: am_valid_o=1 for exactly one cycle, timer cleared, go to WAIT.
- WAIT: timer increments each cycle.
  - am_valid_i captures am_idx_i and am_data_i, then goes to FILTER.
  - timer==TIMEOUT-1 with no am_valid_i pulses frame_err_o, clears the filter history, and returns to COLLECT.
- am_valid_i outside WAIT is ignored.
- FILTER (one cycle):
  - If conf<CONF_MIN: run count=0, candidate kept.
  - Else if idx==candidate: run count increments, saturating at STABLE_N.
  - Else: candidate=idx, run count=1.
  - Go to OUTPUT only when the updated run count equals STABLE_N and the previous count was STABLE_N-1. This gives one emission per stable run. Otherwise return to COLLECT.
- OUTPUT: res_valid_o=1. res_idx_o and res_conf_o are stable until res_ready_i is sampled high, then the block returns to COLLECT.
- score_ready_o=0 in LAUNCH, WAIT, FILTER and OUTPUT, so the upstream layer is backpressured.
- am_data_o is written only by accepted COLLECT beats and is stable from LAUNCH through WAIT.
- Comparisons are unsigned 8-bit.

## Timing
- Reset values:
  - score_ready_o=0 while reset is high, and 1 in the first cycle after deassertion.
  - am_valid_o, res_valid_o, frame_err_o and busy_o are 0.
  - res_idx_o=0, res_conf_o=0, all am_data_o slots=0.
  - cnt=0, run count=0, candidate=5'h1F (no class).
- Reset at any point abandons the current frame and any pending result, and clears the filter history.
- Last beat accepted in cycle T:
  - LAUNCH and am_valid_o in T+1.
  - With ARGMAX_LAT=3, am_valid_i arrives in T+4.
  - FILTER in T+5.
  - res_valid_o in T+6 when emitting.
  - score_ready_o returns in T+6 if not emitting, otherwise in the cycle after the res handshake.
- res_ready_i may be held high before res_valid_o rises; the handshake then completes in the first OUTPUT cycle.
- Simultaneous am_valid_i and timer==TIMEOUT-1: the capture wins and no error is raised.
- The minimum frame period is NUM_CLASS+5 cycles.

## Test plan
- 29 beats with slot 7=8'hC8, all others 8'h10, sent 3 times back-to-back:
  - no output after frames 1 and 2;
  - after frame 3, res_idx_o=7 and res_conf_o=8'hC8 in T+6;
  - a fourth identical frame emits nothing.
- 3 frames winning idx 12 with score 8'h30 (<CONF_MIN): no res_valid_o. A following 3 frames with idx 12 at 8'h90 emit idx 12.
- Frame alternating winner 4/5/4 (each 8'hF0): no emission; run count is 1 after every frame.
- Short frame (last on beat 20): frame_err_o pulse, cnt=0. Long frame (30 beats): error at beat 29, then DRAIN until last. The next good frame classifies correctly.
- Argmax stub never returns: frame_err_o exactly TIMEOUT cycles after WAIT entry, then COLLECT. A late am_valid_i is ignored.
- res_ready_i held low 10 cycles: res_valid_o, res_idx_o and res_conf_o stay stable and score_ready_o stays 0. A mid-OUTPUT reset gives res_valid_o=0 and candidate=5'h1F on the next cycle.

Source files
------------

// File: rtl/asl_result_sequencer.sv
// asl_result_sequencer: collects one frame of class scores and launches it into the argmax tree.
// The winning index then passes a confidence threshold and an N-frame stability filter, and each
// stable letter is handed to the display/UART consumer over a valid/ready handshake.
module asl_result_sequencer #(
  parameter int         NUM_CLASS  = 29,
  parameter int         ARGMAX_LAT = 3,
  parameter int         TIMEOUT    = 15,
  parameter logic [7:0] CONF_MIN   = 8'd64,
  parameter int         STABLE_N   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] score_i,
  input  logic       score_valid_i,
  input  logic       score_last_i,
  output logic       score_ready_o,
  output logic [7:0] am_data_o [NUM_CLASS],
  output logic       am_valid_o,
  input  logic [7:0] am_data_i,
  input  logic [4:0] am_idx_i,
  input  logic       am_valid_i,
  output logic [4:0] res_idx_o,
  output logic [7:0] res_conf_o,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(NUM_CLASS);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int RUN_W = $clog2(STABLE_N + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CLASS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(STABLE_N);
  localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(STABLE_N - 1);
  localparam logic [4:0]       NO_CLASS = 5'h1F;

  // The argmax result must be able to arrive before the wait window closes.
  generate
    if (ARGMAX_LAT >= TIMEOUT) begin : g_bad_timeout
      $error("asl_result_sequencer: TIMEOUT must exceed ARGMAX_LAT");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_COLLECT,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT,
    S_FILTER,
    S_OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [4:0]         cand_q, cand_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [4:0]         idx_q, idx_d;
  logic [7:0]         conf_q, conf_d;
  logic [7:0]         slot_q [NUM_CLASS];
  logic               slot_we;
  logic               beat_acc;

  // Upstream is only accepted while gathering or discarding beats; held off during reset.
  assign score_ready_o = ~reset & ((state_q == S_COLLECT) | (state_q == S_DRAIN));
  assign beat_acc      = score_valid_i & score_ready_o;
  assign busy_o        = ~((state_q == S_COLLECT) && (cnt_q == '0));
  assign res_idx_o     = idx_q;
  assign res_conf_o    = conf_q;

  generate
    for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_am_data
      assign am_data_o[gi] = slot_q[gi];
    end
  endgenerate

  // Next-state logic, strobes and filter update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    cand_d      = cand_q;
    run_d       = run_q;
    idx_d       = idx_q;
    conf_d      = conf_q;
    slot_we     = 1'b0;
    am_valid_o  = 1'b0;
    res_valid_o = 1'b0;
    frame_err_o = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (beat_acc) begin
          slot_we = 1'b1;
          if (score_last_i) begin
            cnt_d = '0;
            if (cnt_q == CNT_LAST) begin
              state_d = S_LAUNCH;
            end else begin
              frame_err_o = 1'b1;  // short frame
            end
          end else if (cnt_q == CNT_LAST) begin
            frame_err_o = 1'b1;    // long frame: discard the rest
            cnt_d       = '0;
            state_d     = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (beat_acc && score_last_i) begin
          state_d = S_COLLECT;
        end
      end
      S_LAUNCH: begin
        am_valid_o = 1'b1;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (am_valid_i) begin
          // A result on the last permitted cycle still counts.
          idx_d   = am_idx_i;
          conf_d  = am_data_i;
          state_d = S_FILTER;
        end else if (timer_q == TMR_LAST) begin
          frame_err_o = 1'b1;
          cand_d      = NO_CLASS;
          run_d       = '0;
          state_d     = S_COLLECT;
        end
      end
      S_FILTER: begin
        if (conf_q < CONF_MIN) begin
          run_d = '0;
        end else if (idx_q == cand_q) begin
          run_d = (run_q == RUN_FULL) ? run_q : run_q + RUN_W'(1);
        end else begin
          cand_d = idx_q;
          run_d  = RUN_W'(1);
        end
        // Emit only on the transition into a full run, so one letter per stable run.
        if (run_d == RUN_FULL && run_q == RUN_PRE) begin
          state_d = S_OUTPUT;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_OUTPUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // Control and filter-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      timer_q <= '0;
      cand_q  <= NO_CLASS;
      run_q   <= '0;
      idx_q   <= '0;
      conf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      idx_q   <= idx_d;
      conf_q  <= conf_d;
    end
  end

  // Score vector: each accepted COLLECT beat lands in the slot addressed by the beat count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (reset) begin
        slot_q[k] <= '0;
      end else if (slot_we && cnt_q == CNT_W'(k)) begin
        slot_q[k] <= score_i;
      end
    end
  end

endmodule

// File: tb/tb_asl_result_sequencer.sv
// Bench for asl_result_sequencer: argmax stub with 3-cycle latency, frame-level model of the
// confidence/stability filter, directed scenarios followed by randomized frames.
module tb_asl_result_sequencer;
  localparam int NC = 29;
  typedef logic [7:0] frame_t [NC];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] score_i = '0;
  logic       score_valid_i = 1'b0;
  logic       score_last_i = 1'b0;
  logic       score_ready_o;
  logic [7:0] am_data_o [NC];
  logic       am_valid_o;
  logic [7:0] am_data_i = '0;
  logic [4:0] am_idx_i = '0;
  logic       am_valid_i = 1'b0;
  logic [4:0] res_idx_o;
  logic [7:0] res_conf_o;
  logic       res_valid_o;
  logic       res_ready_i = 1'b1;
  logic       frame_err_o;
  logic       busy_o;

  always #5 clk = ~clk;

  asl_result_sequencer dut (
    .clk(clk), .reset(reset),
    .score_i(score_i), .score_valid_i(score_valid_i), .score_last_i(score_last_i),
    .score_ready_o(score_ready_o),
    .am_data_o(am_data_o), .am_valid_o(am_valid_o),
    .am_data_i(am_data_i), .am_idx_i(am_idx_i), .am_valid_i(am_valid_i),
    .res_idx_o(res_idx_o), .res_conf_o(res_conf_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;

  // Observed handshakes and error pulses.
  logic [12:0] got_q [$];
  int          err_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid_o && res_ready_i) got_q.push_back({res_idx_o, res_conf_o});
      if (frame_err_o) err_cnt++;
    end
  end

  // Reference model: streak of qualifying frames with the same winner; emit when it reaches 3.
  logic [12:0] exp_q [$];
  int          m_cand = -1;
  int          m_streak = 0;
  int          ck = 0;

  // Argmax stub state.
  bit         stub_en = 1'b1;
  bit         inj = 1'b0;
  int         cd = 0;
  logic [4:0] stub_idx = '0;
  logic [7:0] stub_sc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input int w, input logic [7:0] s);
    if (s < 8'd64) begin
      m_streak = 0;
    end else if (w == m_cand) begin
      m_streak++;
    end else begin
      m_cand   = w;
      m_streak = 1;
    end
    if (m_streak == 3) exp_q.push_back({5'(w), s});
  endtask

  task automatic model_clear();
    m_cand   = -1;
    m_streak = 0;
  endtask

  // One clock: stub runs first, then this cycle's beat inputs are applied, then outputs settle.
  task automatic next(input bit v, input bit l, input logic [7:0] d);
    @(posedge clk);
    #1;
    am_valid_i = 1'b0;
    if (inj) begin
      am_valid_i = 1'b1;
      am_idx_i   = 5'd2;
      am_data_i  = 8'hFF;
      inj        = 1'b0;
    end else if (am_valid_o && stub_en) begin
      int bi = 0;
      for (int k = 1; k < NC; k++) if (am_data_o[k] > am_data_o[bi]) bi = k;
      stub_idx = 5'(bi);
      stub_sc  = am_data_o[bi];
      cd       = 3;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        am_valid_i = 1'b1;
        am_idx_i   = stub_idx;
        am_data_i  = stub_sc;
      end
    end
    score_valid_i = v;
    score_last_i  = l;
    score_i       = d;
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit l);
    int g = 0;
    do begin
      next(1'b1, l, d);
      g++;
    end while (!score_ready_o && g < 100);
    chk("beat_accept", score_ready_o, 1'b1);
  endtask

  task automatic send_frame(input frame_t f, input int nb);
    for (int b = 0; b < nb; b++) begin
      if (b < NC) send_beat(f[b], b == nb - 1);
      else        send_beat(8'h55, b == nb - 1);
    end
  endtask

  task automatic wait_idle(input bit rnd_ready);
    int g = 0;
    do begin
      if (rnd_ready) res_ready_i = 1'($urandom_range(0, 1));
      next(1'b0, 1'b0, 8'h00);
      g++;
    end while (!score_ready_o && g < 100);
    chk("idle_bound", score_ready_o, 1'b1);
    res_ready_i = 1'b1;
  endtask

  task automatic check_emits(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (ck < got_q.size() && ck < exp_q.size()) begin
      chk({tag, "_result"}, got_q[ck], exp_q[ck]);
      $display("[TB] %s emit #%0d idx=%0d conf=%02h", tag, ck, got_q[ck][12:8], got_q[ck][7:0]);
      ck++;
    end
  endtask

  function automatic frame_t mk(input int w, input logic [7:0] s, input bit rnd);
    frame_t f;
    for (int k = 0; k < NC; k++) f[k] = rnd ? 8'($urandom_range(0, int'(s) - 1)) : 8'h10;
    f[w] = s;
    return f;
  endfunction

  task automatic run_frame(input string tag, input int w, input logic [7:0] s, input bit rnd);
    send_frame(mk(w, s, rnd), NC);
    model_frame(w, s);
    wait_idle(rnd);
    check_emits(tag);
    $display("[TB] %s frame idx=%0d score=%02h", tag, w, s);
  endtask

  task automatic do_reset();
    bit zero_ok;
    reset         = 1'b1;
    score_valid_i = 1'b0;
    res_ready_i   = 1'b1;
    next(1'b0, 1'b0, 8'h00);
    next(1'b0, 1'b0, 8'h00);
    chk("rst_ready_low", score_ready_o, 1'b0);
    reset = 1'b0;
    cd    = 0;
    model_clear();
    #1;
    chk("rst_ready_high", score_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_am_valid", am_valid_o, 1'b0);
    chk("rst_err", frame_err_o, 1'b0);
    chk("rst_res_idx", res_idx_o, 5'd0);
    chk("rst_res_conf", res_conf_o, 8'd0);
    zero_ok = 1'b1;
    for (int k = 0; k < NC; k++) if (am_data_o[k] !== 8'h00) zero_ok = 1'b0;
    chk("rst_am_data", zero_ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bit hold_ok;
    logic [12:0] held;

    do_reset();

    // Stable letter 7: frames 1-2 silent, frame 3 emits in T+6, frame 4 silent.
    run_frame("stab1", 7, 8'hC8, 1'b0);
    run_frame("stab2", 7, 8'hC8, 1'b0);
    send_frame(mk(7, 8'hC8, 1'b0), NC);
    model_frame(7, 8'hC8);
    next(1'b0, 1'b0, 8'h00);
    chk("launch_T1", am_valid_o, 1'b1);
    chk("ready_T1", score_ready_o, 1'b0);
    for (int k = 2; k <= 5; k++) next(1'b0, 1'b0, 8'h00);
    chk("res_valid_T5", res_valid_o, 1'b0);
    next(1'b0, 1'b0, 8'h00);
    chk("res_valid_T6", res_valid_o, 1'b1);
    chk("res_idx_T6", res_idx_o, 5'd7);
    chk("res_conf_T6", res_conf_o, 8'hC8);
    chk("ready_T6", score_ready_o, 1'b0);
    next(1'b0, 1'b0, 8'h00);
    chk("ready_T7", score_ready_o, 1'b1);
    check_emits("stab3");
    run_frame("stab4", 7, 8'hC8, 1'b0);

    // Low confidence never qualifies; the same index at high confidence does.
    for (int k = 0; k < 3; k++) run_frame("lowconf", 12, 8'h30, 1'b0);
    for (int k = 0; k < 3; k++) run_frame("hiconf", 12, 8'h90, 1'b0);

    // Threshold boundary: 64 qualifies, 63 breaks the run.
    run_frame("bnd", 6, 8'd64, 1'b0);
    run_frame("bnd", 6, 8'd64, 1'b0);
    run_frame("bnd", 6, 8'd63, 1'b0);
    for (int k = 0; k < 3; k++) run_frame("bnd", 6, 8'd64, 1'b0);

    // Alternating winners keep the run at 1; two more 4s then complete a run.
    run_frame("alt", 4, 8'hF0, 1'b0);
    run_frame("alt", 5, 8'hF0, 1'b0);
    run_frame("alt", 4, 8'hF0, 1'b0);
    run_frame("alt", 4, 8'hF0, 1'b0);
    run_frame("alt", 4, 8'hF0, 1'b0);

    // Short and long frames error out without touching the filter history.
    run_frame("err", 11, 8'hA0, 1'b0);
    run_frame("err", 11, 8'hA0, 1'b0);
    e0 = err_cnt;
    send_frame(mk(11, 8'hA0, 1'b0), 21);
    chk("short_err", frame_err_o, 1'b1);
    next(1'b0, 1'b0, 8'h00);
    chk("short_cnt0_busy", busy_o, 1'b0);
    chk("short_ready", score_ready_o, 1'b1);
    for (int b = 0; b < NC - 1; b++) send_beat(8'h20, 1'b0);
    chk("long_pre_err", frame_err_o, 1'b0);
    send_beat(8'h20, 1'b0);
    chk("long_err", frame_err_o, 1'b1);
    send_beat(8'h20, 1'b1);
    chk("drain_busy", busy_o, 1'b1);
    chk("drain_no_err", frame_err_o, 1'b0);
    next(1'b0, 1'b0, 8'h00);
    chk("drain_exit_busy", busy_o, 1'b0);
    chk("err_pulses", err_cnt - e0, 2);
    $display("[TB] short/long frames errors=%0d", err_cnt - e0);
    run_frame("err", 11, 8'hA0, 1'b0);

    // Timeout: argmax never answers; history is cleared; a late result is ignored.
    do_reset();
    run_frame("tmo", 3, 8'hA0, 1'b0);
    run_frame("tmo", 3, 8'hA0, 1'b0);
    stub_en = 1'b0;
    e0 = err_cnt;
    send_frame(mk(3, 8'hA0, 1'b0), NC);
    model_clear();
    for (int k = 1; k <= 15; k++) next(1'b0, 1'b0, 8'h00);
    chk("tmo_err_T15", frame_err_o, 1'b0);
    next(1'b0, 1'b0, 8'h00);
    chk("tmo_err_T16", frame_err_o, 1'b1);
    chk("tmo_ready_T16", score_ready_o, 1'b0);
    next(1'b0, 1'b0, 8'h00);
    chk("tmo_ready_T17", score_ready_o, 1'b1);
    chk("tmo_err_once", err_cnt - e0, 1);
    inj = 1'b1;
    next(1'b0, 1'b0, 8'h00);
    next(1'b0, 1'b0, 8'h00);
    chk("late_ready", score_ready_o, 1'b1);
    chk("late_busy", busy_o, 1'b0);
    chk("late_res_valid", res_valid_o, 1'b0);
    stub_en = 1'b1;
    $display("[TB] timeout frame handled");
    for (int k = 0; k < 3; k++) run_frame("post_tmo", 3, 8'hA0, 1'b0);

    // Consumer stalls in OUTPUT, then a reset abandons the pending result.
    do_reset();
    res_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_frame(mk(9, 8'hB0, 1'b0), NC);
      wait_idle(1'b0);
      res_ready_i = 1'b0;
    end
    send_frame(mk(9, 8'hB0, 1'b0), NC);
    for (int k = 1; k <= 6; k++) next(1'b0, 1'b0, 8'h00);
    chk("hold_valid", res_valid_o, 1'b1);
    held    = {res_idx_o, res_conf_o};
    chk("hold_result", held, {5'd9, 8'hB0});
    hold_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next(1'b0, 1'b0, 8'h00);
      if (!res_valid_o || {res_idx_o, res_conf_o} !== held || score_ready_o) hold_ok = 1'b0;
    end
    chk("hold_stable", hold_ok, 1'b1);
    reset = 1'b1;
    next(1'b0, 1'b0, 8'h00);
    chk("rst_mid_output", res_valid_o, 1'b0);
    reset       = 1'b0;
    res_ready_i = 1'b1;
    cd          = 0;
    model_clear();
    check_emits("hold");
    for (int k = 0; k < 3; k++) run_frame("post_rst", 9, 8'hB0, 1'b0);

    // Randomized frames with a random consumer.
    for (int n = 0; n < 30; n++) begin
      int w;
      logic [7:0] s;
      case ($urandom_range(0, 2))
        0:       w = 3;
        1:       w = 20;
        default: w = 28;
      endcase
      if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(1, 63));
      else                           s = 8'($urandom_range(64, 255));
      run_frame("rnd", w, s, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
